// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results win over a one-entry memory result buffer,
// with a pending-destination scoreboard. Define WB_BYPASS_EN to enable writeback forwarding.
module regfile_writeback #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alu_valid_i,
    input  logic [4:0]        alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,

    input  logic              mem_valid_i,
    input  logic [4:0]        mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ready_o,

    input  logic              issue_valid_i,
    input  logic [4:0]        issue_rd_i,

    input  logic [4:0]        q_rs_i,
    input  logic [4:0]        q_rt_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,

    output logic              rs_fwd_hit_o,
    output logic [DATA_W-1:0] rs_fwd_data_o,
    output logic              rt_fwd_hit_o,
    output logic [DATA_W-1:0] rt_fwd_data_o,

    output logic [4:0]        RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic              RegWrite_o
);

    logic              buf_valid;
    logic [4:0]        buf_rd;
    logic [DATA_W-1:0] buf_data;

    logic [31:0]       pending;
    logic [31:0]       pending_nxt;

    logic              mem_fire;
    logic              buf_drain;

    // The buffer can always accept when it is empty or when it drains this cycle.
    assign mem_ready_o = !buf_valid || !alu_valid_i;
    assign mem_fire    = mem_valid_i && mem_ready_o;
    assign buf_drain   = buf_valid && !alu_valid_i;

    // Stage p0 -> p1: memory result buffer (drain and refill may share a cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else if (mem_fire) begin
            buf_valid <= 1'b1;
        end else if (buf_drain) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_fire) begin
            buf_rd   <= mem_rd_i;
            buf_data <= mem_data_i;
        end
    end

    // Scoreboard update; a same-cycle set overrides the drain's clear.
    always_comb begin
        pending_nxt = pending;
        if (buf_drain) begin
            pending_nxt[buf_rd] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != 5'd0)) begin
            pending_nxt[issue_rd_i] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs_busy_o = (q_rs_i != 5'd0) && pending[q_rs_i];
    assign rt_busy_o = (q_rt_i != 5'd0) && pending[q_rt_i];

    // Stage p1 -> p2: registered register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= 5'd0;
            RDdata_o   <= '0;
        end else if (alu_valid_i) begin
            RegWrite_o <= (alu_rd_i != 5'd0);
            RDaddr_o   <= alu_rd_i;
            RDdata_o   <= alu_data_i;
        end else if (buf_drain) begin
            RegWrite_o <= (buf_rd != 5'd0);
            RDaddr_o   <= buf_rd;
            RDdata_o   <= buf_data;
        end else begin
            RegWrite_o <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs_fwd_hit_o  = RegWrite_o && (RDaddr_o == q_rs_i) && (q_rs_i != 5'd0);
    assign rs_fwd_data_o = RDdata_o;
    assign rt_fwd_hit_o  = RegWrite_o && (RDaddr_o == q_rt_i) && (q_rt_i != 5'd0);
    assign rt_fwd_data_o = RDdata_o;
`else
    assign rs_fwd_hit_o  = 1'b0;
    assign rs_fwd_data_o = '0;
    assign rt_fwd_hit_o  = 1'b0;
    assign rt_fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;

    localparam int DATA_W = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              alu_valid_i;
    logic [4:0]        alu_rd_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              mem_valid_i;
    logic [4:0]        mem_rd_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ready_o;
    logic              issue_valid_i;
    logic [4:0]        issue_rd_i;
    logic [4:0]        q_rs_i;
    logic [4:0]        q_rt_i;
    logic              rs_busy_o;
    logic              rt_busy_o;
    logic              rs_fwd_hit_o;
    logic [DATA_W-1:0] rs_fwd_data_o;
    logic              rt_fwd_hit_o;
    logic [DATA_W-1:0] rt_fwd_data_o;
    logic [4:0]        RDaddr_o;
    logic [DATA_W-1:0] RDdata_o;
    logic              RegWrite_o;

    int total = 0;
    int bad   = 0;

    regfile_writeback #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .mem_ready_o(mem_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .q_rs_i(q_rs_i), .q_rt_i(q_rt_i), .rs_busy_o(rs_busy_o), .rt_busy_o(rt_busy_o),
        .rs_fwd_hit_o(rs_fwd_hit_o), .rs_fwd_data_o(rs_fwd_data_o),
        .rt_fwd_hit_o(rt_fwd_hit_o), .rt_fwd_data_o(rt_fwd_data_o),
        .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        mem_valid_i = 1'b0; mem_rd_i = '0; mem_data_i = '0;
        issue_valid_i = 1'b0; issue_rd_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        q_rs_i = 5'd3; q_rt_i = 5'd3;
        #12;
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b want=0", RegWrite_o); end
        total++; if (RDaddr_o !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", RDaddr_o); end
        total++; if (RDdata_o !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", RDdata_o); end
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", mem_ready_o); end
        total++; if (rs_busy_o !== 1'b0 || rt_busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b%0b want=00", rs_busy_o, rt_busy_o); end
        total++; if (rs_fwd_hit_o !== 1'b0 || rt_fwd_hit_o !== 1'b0) begin bad++; $display("FAIL rst_fwd got=%0b%0b want=00", rs_fwd_hit_o, rt_fwd_hit_o); end
        rst_n = 1'b1;
        tick();
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL idle_we got=%0b want=0", RegWrite_o); end
    endtask

    task automatic test_alu_only();
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h1234;
        tick();
        alu_valid_i = 1'b0;
        q_rs_i = 5'd5; q_rt_i = 5'd6;
        #1;
        total++; if (RegWrite_o !== 1'b1) begin bad++; $display("FAIL alu_we got=%0b want=1", RegWrite_o); end
        total++; if (RDaddr_o !== 5'd5) begin bad++; $display("FAIL alu_addr got=%0d want=5", RDaddr_o); end
        total++; if (RDdata_o !== 32'h1234) begin bad++; $display("FAIL alu_data got=%h want=1234", RDdata_o); end
        total++; if (rs_fwd_hit_o !== BYP) begin bad++; $display("FAIL fwd_rs_hit got=%0b want=%0b", rs_fwd_hit_o, BYP); end
        total++; if (rs_fwd_data_o !== (BYP ? 32'h1234 : 32'h0)) begin bad++; $display("FAIL fwd_rs_data got=%h want=%h", rs_fwd_data_o, BYP ? 32'h1234 : 32'h0); end
        total++; if (rt_fwd_hit_o !== 1'b0) begin bad++; $display("FAIL fwd_rt_miss got=%0b want=0", rt_fwd_hit_o); end
        tick();
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL alu_we_next got=%0b want=0", RegWrite_o); end
        total++; if (RDaddr_o !== 5'd5 || RDdata_o !== 32'h1234) begin bad++; $display("FAIL alu_hold got=%0d/%h want=5/1234", RDaddr_o, RDdata_o); end
    endtask

    task automatic test_mem_path();
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        issue_valid_i = 1'b0;
        q_rt_i = 5'd7;
        mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'hAA;
        #1;
        total++; if (rt_busy_o !== 1'b1) begin bad++; $display("FAIL mem_busy_pre got=%0b want=1", rt_busy_o); end
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL mem_ready got=%0b want=1", mem_ready_o); end
        tick();
        mem_valid_i = 1'b0;
        #1;
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL mem_we_early got=%0b want=0", RegWrite_o); end
        total++; if (rt_busy_o !== 1'b1) begin bad++; $display("FAIL mem_busy_buf got=%0b want=1", rt_busy_o); end
        tick();
        total++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd7 || RDdata_o !== 32'hAA) begin bad++; $display("FAIL mem_write got=%0b/%0d/%h want=1/7/aa", RegWrite_o, RDaddr_o, RDdata_o); end
        total++; if (rt_busy_o !== 1'b0) begin bad++; $display("FAIL mem_busy_post got=%0b want=0", rt_busy_o); end
        tick();
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL mem_we_after got=%0b want=0", RegWrite_o); end
    endtask

    task automatic test_alu_priority();
        logic [4:0] alu_rds [3];
        alu_rds[0] = 5'd1; alu_rds[1] = 5'd2; alu_rds[2] = 5'd4;
        mem_valid_i = 1'b1; mem_rd_i = 5'd3; mem_data_i = 32'h33;
        tick();
        mem_rd_i = 5'd6; mem_data_i = 32'h66;
        for (int i = 0; i < 3; i++) begin
            alu_valid_i = 1'b1; alu_rd_i = alu_rds[i]; alu_data_i = 32'h100 + i;
            #1;
            total++; if (mem_ready_o !== 1'b0) begin bad++; $display("FAIL pri_ready_%0d got=%0b want=0", i, mem_ready_o); end
            tick();
            total++; if (RegWrite_o !== 1'b1 || RDaddr_o !== alu_rds[i] || RDdata_o !== 32'h100 + i) begin bad++; $display("FAIL pri_alu_%0d got=%0b/%0d/%h want=1/%0d/%h", i, RegWrite_o, RDaddr_o, RDdata_o, alu_rds[i], 32'h100 + i); end
        end
        alu_valid_i = 1'b0;
        #1;
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL pri_ready_drain got=%0b want=1", mem_ready_o); end
        tick();
        mem_valid_i = 1'b0;
        total++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd3 || RDdata_o !== 32'h33) begin bad++; $display("FAIL pri_mem1 got=%0b/%0d/%h want=1/3/33", RegWrite_o, RDaddr_o, RDdata_o); end
        tick();
        total++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd6 || RDdata_o !== 32'h66) begin bad++; $display("FAIL pri_mem2 got=%0b/%0d/%h want=1/6/66", RegWrite_o, RDaddr_o, RDdata_o); end
        tick();
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL pri_idle got=%0b want=0", RegWrite_o); end
    endtask

    task automatic test_x0();
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFF;
        tick();
        alu_valid_i = 1'b0;
        total++; if (RegWrite_o !== 1'b0) begin bad++; $display("FAIL x0_we got=%0b want=0", RegWrite_o); end
        total++; if (RDaddr_o !== 5'd0 || RDdata_o !== 32'hFFFF) begin bad++; $display("FAIL x0_port got=%0d/%h want=0/ffff", RDaddr_o, RDdata_o); end
        issue_valid_i = 1'b1; issue_rd_i = 5'd0;
        tick();
        issue_valid_i = 1'b0;
        q_rs_i = 5'd0; q_rt_i = 5'd0;
        #1;
        total++; if (rs_busy_o !== 1'b0 || rt_busy_o !== 1'b0) begin bad++; $display("FAIL x0_busy got=%0b%0b want=00", rs_busy_o, rt_busy_o); end
    endtask

    task automatic test_back_to_back();
        q_rs_i = 5'd9;
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        tick();
        issue_valid_i = 1'b0;
        mem_valid_i = 1'b1; mem_rd_i = 5'd9; mem_data_i = 32'h99;
        tick();
        mem_valid_i = 1'b0;
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        tick();
        issue_valid_i = 1'b0;
        total++; if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd9 || RDdata_o !== 32'h99) begin bad++; $display("FAIL b2b_write got=%0b/%0d/%h want=1/9/99", RegWrite_o, RDaddr_o, RDdata_o); end
        total++; if (rs_busy_o !== 1'b1) begin bad++; $display("FAIL b2b_set_wins got=%0b want=1", rs_busy_o); end
        mem_valid_i = 1'b1; mem_data_i = 32'h9A;
        tick();
        mem_valid_i = 1'b0;
        total++; if (rs_busy_o !== 1'b1) begin bad++; $display("FAIL b2b_busy_buf got=%0b want=1", rs_busy_o); end
        tick();
        total++; if (rs_busy_o !== 1'b0 || RDdata_o !== 32'h9A) begin bad++; $display("FAIL b2b_clear got=%0b/%h want=0/9a", rs_busy_o, RDdata_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        q_rs_i = 5'd4;
        issue_valid_i = 1'b1; issue_rd_i = 5'd4;
        tick();
        issue_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'h22;
        mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h44;
        #1;
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL rm_ready_pre got=%0b want=1", mem_ready_o); end
        tick();
        idle_inputs();
        alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'h22;
        #1;
        total++; if (RegWrite_o !== 1'b1 || rs_busy_o !== 1'b1 || mem_ready_o !== 1'b0) begin bad++; $display("FAIL rm_setup got=%0b/%0b/%0b want=1/1/0", RegWrite_o, rs_busy_o, mem_ready_o); end
        alu_valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (RegWrite_o !== 1'b0 || RDaddr_o !== 5'd0) begin bad++; $display("FAIL rm_we got=%0b/%0d want=0/0", RegWrite_o, RDaddr_o); end
        total++; if (mem_ready_o !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0b want=1", mem_ready_o); end
        total++; if (rs_busy_o !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", rs_busy_o); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (RegWrite_o !== 1'b0 || rs_busy_o !== 1'b0) begin bad++; $display("FAIL rm_after_%0d got=%0b/%0b want=0/0", i, RegWrite_o, rs_busy_o); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_mem_path();
        test_alu_priority();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the data path and of every data port.
REQ-002 The block SHALL have port clk  in  1  meaning the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  in  1  meaning the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have ALU result ports alu_valid_i  in  1, alu_rd_i  in  5 and alu_data_i  in  DATA_W, meaning a single-cycle result with no backpressure.
REQ-005 The block SHALL have memory/long-latency result ports mem_valid_i  in  1, mem_rd_i  in  5, mem_data_i  in  DATA_W and mem_ready_o  out  1, meaning a valid/ready result channel.
REQ-006 The block SHALL have issue ports issue_valid_i  in  1 and issue_rd_i  in  5, meaning a long-latency instruction has been issued to this destination.
REQ-007 The block SHALL have hazard query ports q_rs_i  in  5, q_rt_i  in  5, rs_busy_o  out  1 and rt_busy_o  out  1.
REQ-008 The block SHALL have bypass ports rs_fwd_hit_o  out  1, rs_fwd_data_o  out  DATA_W, rt_fwd_hit_o  out  1 and rt_fwd_data_o  out  DATA_W.
REQ-009 The block SHALL have register-file write port outputs RDaddr_o  out  5, RDdata_o  out  DATA_W and RegWrite_o  out  1, all registered.

Function
REQ-010 The block SHALL contain a one-entry mem buffer (buf_valid, buf_rd, buf_data); a mem handshake SHALL occur when mem_valid_i && mem_ready_o.
REQ-011 The block SHALL drive mem_ready_o = !buf_valid || !alu_valid_i, combinationally.
REQ-012 Arbitration SHALL be fixed priority, each cycle: alu_valid_i wins; otherwise buf_valid drains; the loser holds.
REQ-013 The winning source SHALL be registered into RDaddr_o/RDdata_o at the next edge, with RegWrite_o = 1 unless rd == 0, in which case RegWrite_o = 0 (no write to x0).
REQ-014 When no source wins, RegWrite_o SHALL be 0 at the next edge, and RDaddr_o/RDdata_o SHALL hold their values.
REQ-015 Latency SHALL be: ALU result at edge N -> RegWrite_o high after edge N; mem handshake at edge N -> RegWrite_o high after edge N+1 at the earliest.
REQ-016 When the buffer drains and a mem handshake occurs in the same cycle, the buffer SHALL load the new entry (no bubble, no loss).
REQ-017 The scoreboard SHALL be a 32-bit pending vector: issue_valid_i with issue_rd_i != 0 sets bit issue_rd_i, and a buffer drain clears bit buf_rd.
REQ-018 When set and clear hit the same bit in the same cycle, set SHALL win; pending[0] SHALL always be 0.
REQ-019 rs_busy_o SHALL equal pending[q_rs_i] combinationally, and rt_busy_o likewise for q_rt_i; both SHALL be 0 for address 0.
REQ-020 Issue to an already-pending rd SHALL leave the bit set, and the first drain to that rd SHALL clear it (single-outstanding-per-rd is the issuer's contract).

Reset
REQ-021 On rst_n low, asynchronously: RegWrite_o = 0, RDaddr_o = 0, RDdata_o = 0, buf_valid = 0, pending = 0.
REQ-022 While rst_n is low: mem_ready_o = 1, busy outputs = 0, fwd hits = 0.
REQ-023 Reset mid-operation SHALL discard buffered data and all pending bits, and the first edge after release SHALL behave as from idle.

Configuration
REQ-024 With macro WB_BYPASS_EN defined: rs_fwd_hit_o = RegWrite_o && (RDaddr_o == q_rs_i) && q_rs_i != 0, with rs_fwd_data_o = RDdata_o; rt likewise.
REQ-025 With WB_BYPASS_EN undefined, all fwd_hit and fwd_data outputs SHALL be tied to 0 and no comparators SHALL be synthesized.

Verification
REQ-026 The bench SHALL cover: ALU only, alu_rd=5, data=0x1234 at edge 0 -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234 after edge 0; RegWrite_o=0 next cycle.
REQ-027 The bench SHALL cover: issue rd=7, then mem rd=7, data=0xAA with ALU idle -> rt_busy_o(q_rt=7)=1 until the drain edge; write of 0xAA after handshake+1; busy then 0.
REQ-028 The bench SHALL cover: ALU valid for 3 cycles while mem rd=3 is buffered -> mem_ready_o=0 during the second mem beat, ALU writes first, mem write lands the cycle after ALU stops.
REQ-029 The bench SHALL cover: ALU rd=0, data=0xFFFF -> RegWrite_o=0; issue rd=0 -> pending stays 0.
REQ-030 The bench SHALL cover: issue rd=9 in the same cycle the buffer drains rd=9 -> pending[9]=1 afterwards.
REQ-031 The bench SHALL cover: rst_n low while buf_valid=1 and pending[4]=1 -> immediate RegWrite_o=0, mem_ready_o=1, rs_busy_o(q_rs=4)=0, and no write after release.
